// File: rtl/clk_div_26mhz_to_1mhz_pkg.sv
// Shared constants and helpers for the 26 MHz to 1 MHz clock divider.
// Holds the default ratio, counter width function and nominal input period.
package clk_div_pkg;

   localparam int unsigned CLK_DIV_26M_1M_RATIO = 26;
   localparam real         CLK_26M_PERIOD_NS    = 38.46;

   function automatic int unsigned cnt_width(input int unsigned n);
      int unsigned w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/clk_div_26mhz_to_1mhz_mod_n_counter.sv
// Modulo-N wrap counter with async active-low clear.
// Flags the terminal count (N-1) and the half count (N/2-1).
module mod_n_counter
   import clk_div_pkg::*;
#(
   parameter int unsigned N = CLK_DIV_26M_1M_RATIO,
   parameter int unsigned W = cnt_width(N)
) (
   input  logic clk_i,
   input  logic rst_ni,
   output logic tc_o,
   output logic half_o
);

   localparam logic [W-1:0] LAST   = W'(N - 1);
   localparam logic [W-1:0] HALFM1 = W'((N / 2) - 1);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Any value at or beyond LAST (including upset states) wraps to zero
   always_comb begin
      cnt_d = cnt_q + W'(1);
      if (cnt_q >= LAST) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o   = (cnt_q == LAST);
   assign half_o = (cnt_q == HALFM1);

endmodule

// File: rtl/clk_div_26mhz_to_1mhz.sv
// Integer divide-by-N clock divider, registered output, low phase first.
// Define CLK_DIV_TICK_EN to add TICK_OUT, a one-cycle pulse on each output rise.
module clk_div_26mhz_to_1mhz
   import clk_div_pkg::*;
#(
   parameter int unsigned DIV_RATIO = CLK_DIV_26M_1M_RATIO
) (
   input  logic CLK_26MHZ_IN,
   input  logic RESET,
   output logic CLK_1MHZ_OUT
`ifdef CLK_DIV_TICK_EN
   ,
   output logic TICK_OUT
`endif
);

   localparam int unsigned CNT_W = cnt_width(DIV_RATIO);

   if (DIV_RATIO < 2) begin : g_bad_ratio
      $error("clk_div_26mhz_to_1mhz: DIV_RATIO must be >= 2");
   end

   logic tc;
   logic half;
   logic clk_q;
   logic clk_d;

   mod_n_counter #(
      .N (DIV_RATIO),
      .W (CNT_W)
   ) u_cnt (
      .clk_i  (CLK_26MHZ_IN),
      .rst_ni (RESET),
      .tc_o   (tc),
      .half_o (half)
   );

   // OR of the flags gives a single toggle if both ever coincide
   always_comb begin
      clk_d = clk_q;
      if (tc || half) begin
         clk_d = ~clk_q;
      end
   end

   always_ff @(posedge CLK_26MHZ_IN or negedge RESET) begin
      if (!RESET) begin
         clk_q <= 1'b0;
      end else begin
         clk_q <= clk_d;
      end
   end

   assign CLK_1MHZ_OUT = clk_q;

`ifdef CLK_DIV_TICK_EN
   logic tick_q;
   logic tick_d;

   always_comb begin
      tick_d = clk_d & ~clk_q;
   end

   always_ff @(posedge CLK_26MHZ_IN or negedge RESET) begin
      if (!RESET) begin
         tick_q <= 1'b0;
      end else begin
         tick_q <= tick_d;
      end
   end

   assign TICK_OUT = tick_q;
`endif

endmodule

// File: tb/tb_clk_div_26mhz_to_1mhz.sv
// Scoreboard bench for the clock divider at ratios 26, 5 and 2.
// Honours CLK_DIV_TICK_EN when the design is built with it.
`timescale 1ns/1ps
module tb_clk_div_26mhz_to_1mhz;
   import clk_div_pkg::*;

   typedef struct packed {
      logic e26;
      logic e5;
      logic e2;
      logic et;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic o26, o5, o2;
   logic t26;

   exp_t        sb[$];
   int unsigned k;
   int          n_chk = 0;
   int          n_fail = 0;
   int          rises;
   int          first_rise;
   int          ticks;
   logic        prev26;

   always #(CLK_26M_PERIOD_NS / 2.0) clk = ~clk;

   clk_div_26mhz_to_1mhz #(.DIV_RATIO(26)) u26 (
      .CLK_26MHZ_IN (clk),
      .RESET        (rst_n),
      .CLK_1MHZ_OUT (o26)
`ifdef CLK_DIV_TICK_EN
      ,
      .TICK_OUT     (t26)
`endif
   );

`ifndef CLK_DIV_TICK_EN
   assign t26 = 1'b0;
`endif

   clk_div_26mhz_to_1mhz #(.DIV_RATIO(5)) u5 (
      .CLK_26MHZ_IN (clk),
      .RESET        (rst_n),
      .CLK_1MHZ_OUT (o5)
`ifdef CLK_DIV_TICK_EN
      ,
      .TICK_OUT     ()
`endif
   );

   clk_div_26mhz_to_1mhz #(.DIV_RATIO(2)) u2 (
      .CLK_26MHZ_IN (clk),
      .RESET        (rst_n),
      .CLK_1MHZ_OUT (o2)
`ifdef CLK_DIV_TICK_EN
      ,
      .TICK_OUT     ()
`endif
   );

   // Output after kk edges since release: low for N/2, then high
   function automatic logic model_out(input int unsigned kk,
                                      input int unsigned n);
      return ((kk % n) >= (n / 2));
   endfunction

   function automatic logic model_tick(input int unsigned kk,
                                       input int unsigned n);
      return (kk != 0) && ((kk % n) == (n / 2));
   endfunction

   task automatic release_reset();
      @(negedge clk);
      rst_n = 1'b1;
      k = 0;
      prev26 = 1'b0;
      rises = 0;
      first_rise = -1;
      ticks = 0;
   endtask

   task automatic assert_reset_at_negedge();
      @(negedge clk);
      rst_n = 1'b0;
      sb.delete();
   endtask

   task automatic step(input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         k++;
         e.e26 = model_out(k, 26);
         e.e5  = model_out(k, 5);
         e.e2  = model_out(k, 2);
`ifdef CLK_DIV_TICK_EN
         e.et  = model_tick(k, 26);
`else
         e.et  = 1'b0;
`endif
         sb.push_back(e);
         @(negedge clk);
         n_chk++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty k=%0d", k);
         end else begin
            e = sb.pop_front();
            if (o26 !== e.e26) begin
               n_fail++;
               $display("FAIL div26 k=%0d got %b want %b", k, o26, e.e26);
            end
            n_chk++;
            if (o5 !== e.e5) begin
               n_fail++;
               $display("FAIL div5 k=%0d got %b want %b", k, o5, e.e5);
            end
            n_chk++;
            if (o2 !== e.e2) begin
               n_fail++;
               $display("FAIL div2 k=%0d got %b want %b", k, o2, e.e2);
            end
`ifdef CLK_DIV_TICK_EN
            n_chk++;
            if (t26 !== e.et) begin
               n_fail++;
               $display("FAIL tick k=%0d got %b want %b", k, t26, e.et);
            end
`endif
         end
         if (!prev26 && o26 === 1'b1) begin
            rises++;
            if (first_rise < 0) first_rise = int'(k);
         end
         if (t26 === 1'b1) ticks++;
         prev26 = o26;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n_chk++;
         if ({o26, o5, o2, t26} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_out cyc=%0d got %b%b%b%b want 0000",
                     i, o26, o5, o2, t26);
         end
         n_chk++;
         if (u26.u_cnt.cnt_q !== '0) begin
            n_fail++;
            $display("FAIL reset_cnt cyc=%0d got %0d want 0",
                     i, u26.u_cnt.cnt_q);
         end
      end
   endtask

   task automatic test_steady_run();
      release_reset();
      step(260);
      n_chk++;
      if (rises != 10) begin
         n_fail++;
         $display("FAIL steady_periods got %0d want 10", rises);
      end
      n_chk++;
      if (first_rise != 13) begin
         n_fail++;
         $display("FAIL steady_first_rise got %0d want 13", first_rise);
      end
   endtask

   task automatic test_mid_reset();
      assert_reset_at_negedge();
      release_reset();
      step(10);
      rst_n = 1'b0;
      sb.delete();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_chk++;
         if (o26 !== 1'b0 || t26 !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_hold cyc=%0d got %b%b want 00",
                     i, o26, t26);
         end
      end
      release_reset();
      step(13);
      n_chk++;
      if (first_rise != 13) begin
         n_fail++;
         $display("FAIL midrst_rise got %0d want 13", first_rise);
      end
   endtask

   task automatic test_reset_while_high();
      assert_reset_at_negedge();
      release_reset();
      step(18);
      n_chk++;
      if (o26 !== 1'b1) begin
         n_fail++;
         $display("FAIL high_before_rst got %b want 1", o26);
      end
      #5;
      rst_n = 1'b0;
      sb.delete();
      #1;
      n_chk++;
      if (o26 !== 1'b0 || t26 !== 1'b0) begin
         n_fail++;
         $display("FAIL async_rst_fall got %b%b want 00", o26, t26);
      end
      n_chk++;
      if (u26.u_cnt.cnt_q !== '0) begin
         n_fail++;
         $display("FAIL async_rst_cnt got %0d want 0", u26.u_cnt.cnt_q);
      end
   endtask

   task automatic test_odd_ratio();
      int highs5;
      highs5 = 0;
      release_reset();
      for (int i = 0; i < 10; i++) begin
         step(1);
         if (o5 === 1'b1) highs5++;
      end
      n_chk++;
      if (highs5 != 6) begin
         n_fail++;
         $display("FAIL div5_high_count got %0d want 6", highs5);
      end
      step(20);
   endtask

   task automatic test_tick();
      assert_reset_at_negedge();
      release_reset();
      step(78);
`ifdef CLK_DIV_TICK_EN
      n_chk++;
      if (ticks != 3) begin
         n_fail++;
         $display("FAIL tick_count got %0d want 3", ticks);
      end
`endif
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      k = 0;
      test_reset();
      test_steady_run();
      test_mid_reset();
      test_reset_while_high();
      test_odd_ratio();
      test_tick();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
